cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus between the ALU reservation-station result port and the
//  load/store buffer result port. Each requester gets a small result queue; one entry per
//  cycle is granted and broadcast as {tag, data} to every reservation station and the ROB.
//  ALU grants also return the RS number as a finish/free strobe back to the ALU.
// PARAMETERS
//  TAG_W     5   ROB tag width; tag value 0 is the free tag and is never a valid producer tag
//  DATA_W    32  result data width
//  RSN_W     3   ALU reservation-station index width
//  DEPTH     2   entries per requester queue (power of 2, >=2)
// PORTS
//  clk          in   1        clock, all state updates on rising edge
//  rst          in   1        reset, asynchronous, active-low
//  flush        in   1        misprediction flush: discard all queued and in-flight results
//  alu_valid    in   1        ALU result offered
//  alu_rsnum    in   RSN_W    ALU RS slot that produced the result
//  alu_tag      in   TAG_W    destination tag of ALU result
//  alu_data     in   DATA_W   ALU result value
//  alu_ready    out  1        ALU queue not full; alu_valid is accepted only when high
//  lsb_valid    in   1        load/store buffer result offered
//  lsb_tag      in   TAG_W    destination tag of LSB result
//  lsb_data     in   DATA_W   LSB result value
//  lsb_ready    out  1        LSB queue not full
//  cdb_valid    out  1        broadcast valid (registered)
//  cdb_src      out  1        0 = ALU, 1 = LSB
//  cdb_tag      out  TAG_W    broadcast tag
//  cdb_data     out  DATA_W   broadcast data
//  alu_finish   out  1        high with cdb_valid when cdb_src==0; frees RS slot alu_fin_rsnum
//  alu_fin_rsnum out RSN_W    RS slot being freed
// BEHAVIOUR
//  - Reset (rst low, async): queues emptied, cdb_valid/cdb_src/alu_finish = 0, cdb_tag = 0,
//    cdb_data = 0, alu_fin_rsnum = 0, RR pointer = ALU. alu_ready = lsb_ready = 1 once rst high.
//  - Queues: per-source FIFO, wr/rd pointers wrap at DEPTH, count 0..DEPTH. *_ready = (count != DEPTH),
//    combinational from count only (no same-cycle pop pass-through). Push = *_valid & *_ready.
//    Offer with valid while ready low is ignored (source protocol violation, not buffered).
//  - Grant (combinational, each cycle): candidate = each non-empty queue head. Exactly one pop per
//    cycle. Arbitration per CONFIGURATION. No candidates -> no pop.
//  - Output register: at each edge cdb_* load the granted head; cdb_valid = 1 iff a grant occurred,
//    else cdb_valid = 0 and tag/data/rsnum/src return to 0. alu_finish = cdb_valid & ~cdb_src.
//  - Latency: result pushed at edge N into an empty queue with no competitor appears on cdb_* after
//    edge N+1 (one-cycle). No bypass from input to output.
//  - Simultaneous push and pop on the same queue: both occur; count unchanged.
//  - Empty queue with simultaneous push: entry is not eligible until the following cycle.
//  - flush high at an edge: both queues emptied, pushes in that cycle dropped, cdb_valid/alu_finish
//    forced 0 next cycle, RR pointer unchanged. flush overrides every other event.
//  - Reset asserted mid-operation: all queued results lost immediately; no partial broadcast.
//  - Tag 0 entries are queued and broadcast like any other (consumers ignore tag 0).
// CONFIGURATION
//  CDB_RR_EN defined: round-robin. Pointer names the preferred source; when both non-empty the
//    preferred wins and pointer flips to the other; single candidate wins and pointer flips to
//    the non-granted source.
//  CDB_RR_EN undefined: fixed priority, ALU always wins when non-empty; LSB granted only when ALU
//    queue is empty. Pointer logic absent.
// TESTING
//  1. Reset release, idle 5 cycles -> cdb_valid=0, alu_ready=lsb_ready=1, all outputs 0.
//  2. ALU push {rsnum=3,tag=7,data=0x1234} alone -> next cycle cdb_valid=1,src=0,tag=7,
//     data=0x1234,alu_finish=1,alu_fin_rsnum=3; following cycle cdb_valid=0.
//  3. ALU tag 5 and LSB tag 9 pushed same cycle, RR pointer=ALU -> tag 5 then tag 9 on consecutive
//     cycles with CDB_RR_EN; same order without it; repeat with 2 each -> RR: 5,9,5',9';
//     fixed: 5,5',9,9'.
//  4. Push 3 ALU results back-to-back with LSB stream continuously granted (fixed priority off,
//     DEPTH=2) -> alu_ready drops after 2nd push, 3rd held by source, no entry lost or duplicated.
//  5. flush with both queues full and cdb_valid=1 -> next cycle cdb_valid=0, both ready=1, no
//     queued tags ever broadcast; pushes in flush cycle discarded.
//  6. Assert rst mid-stream with ALU count=2 -> outputs 0 immediately (async), queues empty after
//     release, first new push broadcast after one cycle.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result ports from the ALU and load/store buffer plus the common data bus broadcast.
// The slave modport is the arbiter's view. The master modport is the view of the sources and consumers.
interface cdb_arbiter_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int RSN_W  = 3
);
  logic              alu_valid;
  logic [RSN_W-1:0]  alu_rsnum;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              lsb_valid;
  logic [TAG_W-1:0]  lsb_tag;
  logic [DATA_W-1:0] lsb_data;
  logic              lsb_ready;
  logic              cdb_valid;
  logic              cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_finish;
  logic [RSN_W-1:0]  alu_fin_rsnum;

  modport master (
    output alu_valid, alu_rsnum, alu_tag, alu_data, lsb_valid, lsb_tag, lsb_data,
    input  alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_tag, cdb_data,
           alu_finish, alu_fin_rsnum
  );

  modport slave (
    input  alu_valid, alu_rsnum, alu_tag, alu_data, lsb_valid, lsb_tag, lsb_data,
    output alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_tag, cdb_data,
           alu_finish, alu_fin_rsnum
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: a small FIFO per result source, one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; the default build gives the ALU fixed priority.
module cdb_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int RSN_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [RSN_W-1:0]  alu_rsn_q  [DEPTH];
  logic [TAG_W-1:0]  alu_tag_q  [DEPTH];
  logic [DATA_W-1:0] alu_data_q [DEPTH];
  logic [TAG_W-1:0]  lsb_tag_q  [DEPTH];
  logic [DATA_W-1:0] lsb_data_q [DEPTH];

  logic [PTR_W-1:0]  alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0]  lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;

  logic              alu_push_s, lsb_push_s;
  logic              alu_ne_s, lsb_ne_s;
  logic              gnt_alu_s, gnt_lsb_s;

  logic              cdb_valid_q, cdb_valid_d;
  logic              cdb_src_q, cdb_src_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              fin_q, fin_d;
  logic [RSN_W-1:0]  fin_rsn_q, fin_rsn_d;

  // Ready depends only on occupancy; a same-cycle pop does not free space for the source.
  assign alu_ne_s      = (alu_cnt_q != {CNT_W{1'b0}});
  assign lsb_ne_s      = (lsb_cnt_q != {CNT_W{1'b0}});
  assign bus.alu_ready = (alu_cnt_q != FULL_CNT);
  assign bus.lsb_ready = (lsb_cnt_q != FULL_CNT);
  assign alu_push_s    = bus.alu_valid & bus.alu_ready & ~flush_i;
  assign lsb_push_s    = bus.lsb_valid & bus.lsb_ready & ~flush_i;

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_src       = cdb_src_q;
  assign bus.cdb_tag       = cdb_tag_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.alu_finish    = fin_q;
  assign bus.alu_fin_rsnum = fin_rsn_q;

`ifdef CDB_RR_EN
  logic rr_q, rr_d;   // 0: ALU preferred, 1: LSB preferred

  // Round-robin grant between the two queue heads
  always_comb begin
    gnt_alu_s = 1'b0;
    gnt_lsb_s = 1'b0;
    if (alu_ne_s && lsb_ne_s) begin
      gnt_lsb_s = rr_q;
      gnt_alu_s = ~rr_q;
    end else if (alu_ne_s) begin
      gnt_alu_s = 1'b1;
    end else if (lsb_ne_s) begin
      gnt_lsb_s = 1'b1;
    end else begin
      gnt_alu_s = 1'b0;
    end
    if (gnt_alu_s) begin
      rr_d = 1'b1;
    end else if (gnt_lsb_s) begin
      rr_d = 1'b0;
    end else begin
      rr_d = rr_q;
    end
  end

  // Preference pointer; a flush leaves it untouched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else if (flush_i) begin
      rr_q <= rr_q;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed-priority grant: the LSB is served only while the ALU queue is empty
  always_comb begin
    gnt_alu_s = 1'b0;
    gnt_lsb_s = 1'b0;
    if (alu_ne_s) begin
      gnt_alu_s = 1'b1;
    end else if (lsb_ne_s) begin
      gnt_lsb_s = 1'b1;
    end else begin
      gnt_alu_s = 1'b0;
    end
  end
`endif

  // Queue pointer and occupancy next state; flush empties both queues
  always_comb begin
    alu_wr_d  = alu_wr_q;
    alu_rd_d  = alu_rd_q;
    lsb_wr_d  = lsb_wr_q;
    lsb_rd_d  = lsb_rd_q;
    alu_cnt_d = alu_cnt_q;
    lsb_cnt_d = lsb_cnt_q;
    if (flush_i) begin
      alu_wr_d  = {PTR_W{1'b0}};
      alu_rd_d  = {PTR_W{1'b0}};
      lsb_wr_d  = {PTR_W{1'b0}};
      lsb_rd_d  = {PTR_W{1'b0}};
      alu_cnt_d = {CNT_W{1'b0}};
      lsb_cnt_d = {CNT_W{1'b0}};
    end else begin
      alu_wr_d = alu_push_s ? alu_wr_q + PTR_W'(1) : alu_wr_q;
      alu_rd_d = gnt_alu_s  ? alu_rd_q + PTR_W'(1) : alu_rd_q;
      lsb_wr_d = lsb_push_s ? lsb_wr_q + PTR_W'(1) : lsb_wr_q;
      lsb_rd_d = gnt_lsb_s  ? lsb_rd_q + PTR_W'(1) : lsb_rd_q;
      case ({alu_push_s, gnt_alu_s})
        2'b10:   alu_cnt_d = alu_cnt_q + CNT_W'(1);
        2'b01:   alu_cnt_d = alu_cnt_q - CNT_W'(1);
        default: alu_cnt_d = alu_cnt_q;
      endcase
      case ({lsb_push_s, gnt_lsb_s})
        2'b10:   lsb_cnt_d = lsb_cnt_q + CNT_W'(1);
        2'b01:   lsb_cnt_d = lsb_cnt_q - CNT_W'(1);
        default: lsb_cnt_d = lsb_cnt_q;
      endcase
    end
  end

  // Broadcast next state: the granted head, or all zeros when idle or flushing
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_src_d   = 1'b0;
    cdb_tag_d   = {TAG_W{1'b0}};
    cdb_data_d  = {DATA_W{1'b0}};
    fin_d       = 1'b0;
    fin_rsn_d   = {RSN_W{1'b0}};
    if (flush_i) begin
      cdb_valid_d = 1'b0;
    end else if (gnt_alu_s) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = alu_tag_q[alu_rd_q];
      cdb_data_d  = alu_data_q[alu_rd_q];
      fin_d       = 1'b1;
      fin_rsn_d   = alu_rsn_q[alu_rd_q];
    end else if (gnt_lsb_s) begin
      cdb_valid_d = 1'b1;
      cdb_src_d   = 1'b1;
      cdb_tag_d   = lsb_tag_q[lsb_rd_q];
      cdb_data_d  = lsb_data_q[lsb_rd_q];
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  // Queue storage writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        alu_rsn_q[i]  <= {RSN_W{1'b0}};
        alu_tag_q[i]  <= {TAG_W{1'b0}};
        alu_data_q[i] <= {DATA_W{1'b0}};
        lsb_tag_q[i]  <= {TAG_W{1'b0}};
        lsb_data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (alu_push_s) begin
        alu_rsn_q[alu_wr_q]  <= bus.alu_rsnum;
        alu_tag_q[alu_wr_q]  <= bus.alu_tag;
        alu_data_q[alu_wr_q] <= bus.alu_data;
      end
      if (lsb_push_s) begin
        lsb_tag_q[lsb_wr_q]  <= bus.lsb_tag;
        lsb_data_q[lsb_wr_q] <= bus.lsb_data;
      end
    end
  end

  // Pointer, occupancy and broadcast registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_wr_q    <= {PTR_W{1'b0}};
      alu_rd_q    <= {PTR_W{1'b0}};
      lsb_wr_q    <= {PTR_W{1'b0}};
      lsb_rd_q    <= {PTR_W{1'b0}};
      alu_cnt_q   <= {CNT_W{1'b0}};
      lsb_cnt_q   <= {CNT_W{1'b0}};
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 1'b0;
      cdb_tag_q   <= {TAG_W{1'b0}};
      cdb_data_q  <= {DATA_W{1'b0}};
      fin_q       <= 1'b0;
      fin_rsn_q   <= {RSN_W{1'b0}};
    end else begin
      alu_wr_q    <= alu_wr_d;
      alu_rd_q    <= alu_rd_d;
      lsb_wr_q    <= lsb_wr_d;
      lsb_rd_q    <= lsb_rd_d;
      alu_cnt_q   <= alu_cnt_d;
      lsb_cnt_q   <= lsb_cnt_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      fin_q       <= fin_d;
      fin_rsn_q   <= fin_rsn_d;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: cycle vector table, scoreboarded random stream, reset cases.
module tb_cdb_arbiter;
  localparam int TAG_W = 5, DATA_W = 32, RSN_W = 3, NRES = 40;

  typedef struct {
    logic fl; logic av; logic [2:0] ar; logic [4:0] at; logic [31:0] ad;
    logic lv; logic [4:0] lt; logic [31:0] ld;
    logic ev; logic es; logic [4:0] et; logic [31:0] ed; logic [2:0] er; logic ear; logic elr;
  } vec_t;

  typedef struct {
    logic [4:0] tag; logic [31:0] data; logic [2:0] rsn;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vt[27];
  ent_t exp_a[$];
  ent_t exp_l[$];

  always #5 clk = ~clk;

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .RSN_W(RSN_W)) bus ();

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .RSN_W(RSN_W), .DEPTH(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_rsnum = 3'd0; bus.alu_tag = 5'd0; bus.alu_data = 32'd0;
    bus.lsb_valid = 1'b0; bus.lsb_tag = 5'd0; bus.lsb_data = 32'd0;
  endtask

  task automatic chk_all_zero(string nm, int idx);
    chk({nm, "_valid"}, idx, 32'(bus.cdb_valid), 32'd0);
    chk({nm, "_src"}, idx, 32'(bus.cdb_src), 32'd0);
    chk({nm, "_tag"}, idx, 32'(bus.cdb_tag), 32'd0);
    chk({nm, "_data"}, idx, bus.cdb_data, 32'd0);
    chk({nm, "_fin"}, idx, 32'(bus.alu_finish), 32'd0);
    chk({nm, "_finrsn"}, idx, 32'(bus.alu_fin_rsnum), 32'd0);
  endtask

  initial begin
    int   a_sent, l_sent;
    logic a_pend, l_pend, lsb_low_seen, done;
    ent_t e;

    // {flush, alu v/rsn/tag/data, lsb v/tag/data, exp valid/src/tag/data/finrsn/alu_rdy/lsb_rdy}
    vt[0]  = '{1'b0, 1'b1, 3'd3, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 5'd7, 32'h1234, 3'd3, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22,     1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 5'd2, 32'h22, 3'd0, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 3'd1, 5'd5, 32'h55, 1'b1, 5'd9, 32'h99,    1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 5'd5, 32'h55, 3'd1, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 5'd9, 32'h99, 3'd0, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 3'd1, 5'd5, 32'h155, 1'b1, 5'd9, 32'h199,  1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b1, 3'd2, 5'd6, 32'h66, 1'b1, 5'd10, 32'hAA,   1'b1, 1'b0, 5'd5, 32'h155, 3'd1, 1'b1, 1'b0};
`ifdef CDB_RR_EN
    vt[11] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h200,   1'b1, 1'b1, 5'd9, 32'h199, 3'd0, 1'b1, 1'b1};
    vt[12] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 5'd6, 32'h66, 3'd2, 1'b1, 1'b1};
`else
    vt[11] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h200,   1'b1, 1'b0, 5'd6, 32'h66, 3'd2, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 5'd9, 32'h199, 3'd0, 1'b1, 1'b1};
`endif
    vt[13] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 5'd10, 32'hAA, 3'd0, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[15] = '{1'b0, 1'b1, 3'd4, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC1,  1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[16] = '{1'b0, 1'b1, 3'd5, 5'd13, 32'hB2, 1'b1, 5'd14, 32'hC2,  1'b1, 1'b0, 5'd11, 32'hB1, 3'd4, 1'b1, 1'b0};
    vt[17] = '{1'b1, 1'b1, 3'd6, 5'd15, 32'hB3, 1'b1, 5'd16, 32'hC3,  1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[18] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[19] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[20] = '{1'b0, 1'b1, 3'd1, 5'd17, 32'h171, 1'b1, 5'd18, 32'h181, 1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
`ifdef CDB_RR_EN
    vt[21] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 5'd18, 32'h181, 3'd0, 1'b1, 1'b1};
    vt[22] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 5'd17, 32'h171, 3'd1, 1'b1, 1'b1};
`else
    vt[21] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 5'd17, 32'h171, 3'd1, 1'b1, 1'b1};
    vt[22] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b1, 5'd18, 32'h181, 3'd0, 1'b1, 1'b1};
`endif
    vt[23] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[24] = '{1'b0, 1'b1, 3'd7, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0,   1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};
    vt[25] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 5'd0, 32'hDEAD, 3'd7, 1'b1, 1'b1};
    vt[26] = '{1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 1'b1, 1'b1};

    // Reset, then five idle cycles
    drive_idle();
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_valid", i, 32'(bus.cdb_valid), 32'd0);
    end
    chk_all_zero("idle", 5);
    chk("idle_alu_rdy", 5, 32'(bus.alu_ready), 32'd1);
    chk("idle_lsb_rdy", 5, 32'(bus.lsb_ready), 32'd1);

    // Cycle-by-cycle vector table
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      flush = vt[i].fl;
      bus.alu_valid = vt[i].av; bus.alu_rsnum = vt[i].ar; bus.alu_tag = vt[i].at; bus.alu_data = vt[i].ad;
      bus.lsb_valid = vt[i].lv; bus.lsb_tag = vt[i].lt; bus.lsb_data = vt[i].ld;
      @(posedge clk); #1;
      chk("vec_valid", i, 32'(bus.cdb_valid), 32'(vt[i].ev));
      chk("vec_src", i, 32'(bus.cdb_src), 32'(vt[i].es));
      chk("vec_tag", i, 32'(bus.cdb_tag), 32'(vt[i].et));
      chk("vec_data", i, bus.cdb_data, vt[i].ed);
      chk("vec_fin", i, 32'(bus.alu_finish), 32'(vt[i].ev & ~vt[i].es));
      chk("vec_finrsn", i, 32'(bus.alu_fin_rsnum), 32'(vt[i].er));
      chk("vec_alu_rdy", i, 32'(bus.alu_ready), 32'(vt[i].ear));
      chk("vec_lsb_rdy", i, 32'(bus.lsb_ready), 32'(vt[i].elr));
    end
    @(negedge clk);
    flush = 1'b0;
    drive_idle();

    // Random stream: sources hold offers until accepted, the scoreboard tracks per-source order
    a_sent = 0; l_sent = 0; a_pend = 1'b0; l_pend = 1'b0; lsb_low_seen = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      @(negedge clk);
      if (bus.cdb_valid) begin
        if (bus.cdb_src == 1'b0) begin
          chk("sb_alu_expected", cyc, 32'(exp_a.size() != 0), 32'd1);
          if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            chk("sb_alu_tag", cyc, 32'(bus.cdb_tag), 32'(e.tag));
            chk("sb_alu_data", cyc, bus.cdb_data, e.data);
            chk("sb_alu_finrsn", cyc, 32'(bus.alu_fin_rsnum), 32'(e.rsn));
            chk("sb_alu_fin", cyc, 32'(bus.alu_finish), 32'd1);
          end
        end else begin
          chk("sb_lsb_expected", cyc, 32'(exp_l.size() != 0), 32'd1);
          if (exp_l.size() != 0) begin
            e = exp_l.pop_front();
            chk("sb_lsb_tag", cyc, 32'(bus.cdb_tag), 32'(e.tag));
            chk("sb_lsb_data", cyc, bus.cdb_data, e.data);
            chk("sb_lsb_fin", cyc, 32'(bus.alu_finish), 32'd0);
          end
        end
      end
      if (!bus.lsb_ready) lsb_low_seen = 1'b1;
      if (!a_pend && a_sent < NRES && $urandom_range(9) != 0) begin
        bus.alu_rsnum = 3'(a_sent); bus.alu_tag = 5'(a_sent);
        bus.alu_data = 32'h0A00_0000 | 32'(a_sent);
        a_pend = 1'b1; a_sent++;
      end
      if (!l_pend && l_sent < NRES && $urandom_range(9) != 0) begin
        bus.lsb_tag = 5'(l_sent + 7); bus.lsb_data = 32'h0B00_0000 | 32'(l_sent);
        l_pend = 1'b1; l_sent++;
      end
      bus.alu_valid = a_pend;
      bus.lsb_valid = l_pend;
      if (a_pend && bus.alu_ready) begin
        exp_a.push_back('{bus.alu_tag, bus.alu_data, bus.alu_rsnum});
        a_pend = 1'b0;
      end
      if (l_pend && bus.lsb_ready) begin
        exp_l.push_back('{bus.lsb_tag, bus.lsb_data, 3'd0});
        l_pend = 1'b0;
      end
      done = (a_sent == NRES) && (l_sent == NRES) && !a_pend && !l_pend && !bus.alu_valid &&
             !bus.lsb_valid && (exp_a.size() == 0) && (exp_l.size() == 0) && !bus.cdb_valid;
    end
    drive_idle();
    chk("sb_drain_done", 0, 32'(done), 32'd1);
    chk("sb_alu_left", 0, 32'(exp_a.size()), 32'd0);
    chk("sb_lsb_left", 0, 32'(exp_l.size()), 32'd0);
    chk("sb_lsb_backpressure", 0, 32'(lsb_low_seen), 32'd1);

    // Reset asserted mid-stream with results queued and a broadcast on the bus
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_rsnum = 3'd1; bus.alu_tag = 5'd1; bus.alu_data = 32'h501;
    bus.lsb_valid = 1'b1; bus.lsb_tag = 5'd2; bus.lsb_data = 32'h502;
    @(negedge clk);
    bus.alu_rsnum = 3'd3; bus.alu_tag = 5'd3; bus.alu_data = 32'h503;
    bus.lsb_tag = 5'd4; bus.lsb_data = 32'h504;
    @(negedge clk);
    drive_idle();
    chk("rst_pre_valid", 0, 32'(bus.cdb_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async", 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_post_valid", i, 32'(bus.cdb_valid), 32'd0);
      chk("rst_post_alu_rdy", i, 32'(bus.alu_ready), 32'd1);
      chk("rst_post_lsb_rdy", i, 32'(bus.lsb_ready), 32'd1);
    end
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_rsnum = 3'd2; bus.alu_tag = 5'd3; bus.alu_data = 32'h33;
    @(posedge clk); #1;
    drive_idle();
    chk("rst_new_lat0", 0, 32'(bus.cdb_valid), 32'd0);
    @(posedge clk); #1;
    chk("rst_new_valid", 0, 32'(bus.cdb_valid), 32'd1);
    chk("rst_new_tag", 0, 32'(bus.cdb_tag), 32'd3);
    chk("rst_new_data", 0, bus.cdb_data, 32'h33);
    chk("rst_new_fin", 0, 32'(bus.alu_finish), 32'd1);
    chk("rst_new_finrsn", 0, 32'(bus.alu_fin_rsnum), 32'd2);
    @(posedge clk); #1;
    chk("rst_new_after", 0, 32'(bus.cdb_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
